// File: rtl/alu_result_stage_pkg.sv
// Shared types for the ALU result stage: queued write-back entry and architected flags.
// Pure definitions: no latency, no backpressure.
package alu_result_stage_pkg;

   localparam int WB_W    = 8;
   localparam int REG_A   = 3;
   localparam int Q_DEPTH = 2;

   typedef struct packed {
      logic [WB_W-1:0]  data;
      logic [REG_A-1:0] dest;
   } wb_entry_t;

   typedef struct packed {
      logic zero;
      logic parity;
      logic odd;
   } alu_flags_t;

endpackage

// File: rtl/alu_result_stage_if.sv
// ALU-result / write-back / forwarding bundle. The master drives ALU results and write-back ready.
// The slave (the stage) answers with ready, head entry, flags and lookup. Wires only, so it adds no latency.
interface alu_result_stage_if #(
   parameter int W     = 8,
   parameter int A     = 3,
   parameter int DEPTH = 2
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic          InValid;
   logic          InReady;
   logic [W-1:0]  InData;
   logic          InZero;
   logic          InParity;
   logic          InOdd;
   logic [A-1:0]  InDest;
   logic          InFlagWr;
   logic          WbValid;
   logic          WbReady;
   logic [W-1:0]  WbData;
   logic [A-1:0]  WbDest;
   logic          FlagZero;
   logic          FlagParity;
   logic          FlagOdd;
   logic [A-1:0]  FwdAddr;
   logic          FwdHit;
   logic [W-1:0]  FwdData;
   logic [CW-1:0] Count;

   modport master (
      output InValid, InData, InZero, InParity, InOdd, InDest, InFlagWr, WbReady, FwdAddr,
      input  InReady, WbValid, WbData, WbDest, FlagZero, FlagParity, FlagOdd, FwdHit, FwdData, Count
   );

   modport slave (
      input  InValid, InData, InZero, InParity, InOdd, InDest, InFlagWr, WbReady, FwdAddr,
      output InReady, WbValid, WbData, WbDest, FlagZero, FlagParity, FlagOdd, FwdHit, FwdData, Count
   );

endinterface

// File: rtl/alu_result_stage_result_queue.sv
// In-order result queue with a youngest-match forwarding search. A push is visible at the head one edge later.
// The caller gates i_push with !o_full and i_pop with !o_empty.
module alu_result_stage_result_queue
   import alu_result_stage_pkg::*;
#(
   parameter  int DEPTH = Q_DEPTH,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = PW + 1
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             i_push,
   input  logic             i_pop,
   input  wb_entry_t        i_entry,
   input  logic [REG_A-1:0] i_fwd_addr,
   output wb_entry_t        o_head,
   output logic             o_full,
   output logic             o_empty,
   output logic [CW-1:0]    o_count,
   output logic             o_fwd_hit,
   output logic [WB_W-1:0]  o_fwd_data
);

   wb_entry_t     r_mem [DEPTH];
   logic [PW-1:0] r_rd_ptr;
   logic [PW-1:0] r_wr_ptr;
   logic [CW-1:0] r_count;
   logic [PW-1:0] w_idx;

   // Storage is left unreset; r_count alone decides which slots are live.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) begin
            r_mem[r_wr_ptr] <= i_entry;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (i_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_count = r_count;
   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];

   // Walk oldest to youngest so that a later match overrides an earlier one.
   always_comb begin
      o_fwd_hit  = 1'b0;
      o_fwd_data = '0;
      w_idx      = '0;
      for (int k = 0; k < DEPTH; k++) begin
         w_idx = r_rd_ptr + PW'(k);
         if ((CW'(k) < r_count) && (r_mem[w_idx].dest == i_fwd_addr)) begin
            o_fwd_hit  = 1'b1;
            o_fwd_data = r_mem[w_idx].data;
         end
      end
   end

endmodule

// File: rtl/alu_result_stage.sv
// Registers ALU results into a write-back queue and holds the architected flags. Results reach Wb* one edge after acceptance.
// InReady drops only when the queue is full; a same-cycle pop does not free a slot for the incoming result.
module alu_result_stage
   import alu_result_stage_pkg::*;
#(
   parameter int DEPTH = Q_DEPTH
) (
   input logic               Clk,
   input logic               Reset,
   alu_result_stage_if.slave bus
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic            w_push;
   logic            w_pop;
   logic            w_full;
   logic            w_empty;
   logic [CW-1:0]   w_count;
   logic            w_fwd_hit;
   logic [WB_W-1:0] w_fwd_data;
   wb_entry_t       w_in;
   wb_entry_t       w_head;
   alu_flags_t      r_flags;

   assign w_push = bus.InValid & ~w_full;
   assign w_pop  = bus.WbReady & ~w_empty;
   assign w_in   = '{data: bus.InData, dest: bus.InDest};

   alu_result_stage_result_queue #(.DEPTH(DEPTH)) u_queue (
      .Clk        (Clk),
      .Reset      (Reset),
      .i_push     (w_push),
      .i_pop      (w_pop),
      .i_entry    (w_in),
      .i_fwd_addr (bus.FwdAddr),
      .o_head     (w_head),
      .o_full     (w_full),
      .o_empty    (w_empty),
      .o_count    (w_count),
      .o_fwd_hit  (w_fwd_hit),
      .o_fwd_data (w_fwd_data)
   );

   // Flags track acceptance order, so they update at push time rather than at write-back.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         r_flags <= '0;
      end else if (w_push && bus.InFlagWr) begin
         r_flags <= '{zero: bus.InZero, parity: bus.InParity, odd: bus.InOdd};
      end
   end

   assign bus.InReady    = ~w_full;
   assign bus.WbValid    = ~w_empty;
   assign bus.WbData     = w_head.data;
   assign bus.WbDest     = w_head.dest;
   assign bus.FlagZero   = r_flags.zero;
   assign bus.FlagParity = r_flags.parity;
   assign bus.FlagOdd    = r_flags.odd;
   assign bus.FwdHit     = w_fwd_hit;
   assign bus.FwdData    = w_fwd_data;
   assign bus.Count      = w_count;

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: directed scenarios then random traffic against a queue-based reference model.
module tb_alu_result_stage;
   import alu_result_stage_pkg::*;

   localparam int DEPTH = 2;

   typedef struct {
      logic [7:0] data;
      logic [2:0] dest;
   } ent_t;

   logic Clk   = 1'b0;
   logic Reset = 1'b0;

   alu_result_stage_if #(.W(WB_W), .A(REG_A), .DEPTH(DEPTH)) bus ();

   alu_result_stage #(.DEPTH(DEPTH)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   always #5 Clk = ~Clk;

   ent_t       model_q[$];
   ent_t       exp_q[$];
   logic [2:0] mflags = 3'b000;
   int         checks = 0;
   int         failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock cycle: drive inputs after the falling edge, check state-derived outputs, advance the model at the rising edge.
   task automatic step(input bit rst_n, input bit vld, input bit [7:0] d, input bit [2:0] dst,
                       input bit [2:0] zpo, input bit fw, input bit wbr, input bit [2:0] fa);
      bit         push, pop, hit;
      bit [7:0]   fdat;
      ent_t       e;
      Reset        = rst_n;
      bus.InValid  = vld;
      bus.InData   = d;
      bus.InDest   = dst;
      bus.InZero   = zpo[2];
      bus.InParity = zpo[1];
      bus.InOdd    = zpo[0];
      bus.InFlagWr = fw;
      bus.WbReady  = wbr;
      bus.FwdAddr  = fa;
      #1;
      chk("count", 32'(bus.Count), model_q.size());
      chk("in_ready", 32'(bus.InReady), 32'(model_q.size() < DEPTH));
      chk("wb_valid", 32'(bus.WbValid), 32'(model_q.size() != 0));
      if (model_q.size() == 0) chk("wb_empty_zero", 32'({bus.WbDest, bus.WbData}), 0);
      chk("flags", 32'({bus.FlagZero, bus.FlagParity, bus.FlagOdd}), 32'(mflags));
      hit  = 1'b0;
      fdat = 8'h00;
      foreach (model_q[i]) begin
         if (model_q[i].dest == fa) begin
            hit  = 1'b1;
            fdat = model_q[i].data;
         end
      end
      chk("fwd_hit", 32'(bus.FwdHit), 32'(hit));
      chk("fwd_data", 32'(bus.FwdData), 32'(fdat));
      push   = rst_n && vld && (model_q.size() < DEPTH);
      pop    = rst_n && wbr && (model_q.size() != 0);
      e.data = d;
      e.dest = dst;
      if (push) exp_q.push_back(e);
      @(posedge Clk);
      if (!rst_n) begin
         model_q.delete();
         exp_q.delete();
         mflags = 3'b000;
      end else begin
         if (pop) void'(model_q.pop_front());
         if (push) model_q.push_back(e);
         if (push && fw) mflags = zpo;
      end
      @(negedge Clk);
   endtask

   task automatic idle(input bit wbr, input bit [2:0] fa);
      step(1'b1, 1'b0, 8'h00, 3'd0, 3'b000, 1'b0, wbr, fa);
   endtask

   task automatic push1(input bit [7:0] d, input bit [2:0] dst, input bit wbr);
      step(1'b1, 1'b1, d, dst, 3'b000, 1'b0, wbr, 3'd0);
   endtask

   // Scoreboard monitor: every write-back handshake must match the oldest outstanding accepted result.
   initial begin : monitor
      ent_t me;
      forever begin
         @(negedge Clk);
         #2;
         if (Reset && bus.WbValid && bus.WbReady) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL wb_pop: got data %0h with nothing expected at %0t", bus.WbData, $time);
            end else begin
               me = exp_q.pop_front();
               chk("wb_data", 32'(bus.WbData), 32'(me.data));
               chk("wb_dest", 32'(bus.WbDest), 32'(me.dest));
            end
         end
      end
   end

   initial begin : driver
      bus.InValid  = 1'b0;
      bus.InData   = '0;
      bus.InDest   = '0;
      bus.InZero   = 1'b0;
      bus.InParity = 1'b0;
      bus.InOdd    = 1'b0;
      bus.InFlagWr = 1'b0;
      bus.WbReady  = 1'b0;
      bus.FwdAddr  = '0;
      @(negedge Clk);
      // Reset with a valid input present.
      step(1'b0, 1'b1, 8'h77, 3'd1, 3'b111, 1'b1, 1'b0, 3'd1);
      step(1'b0, 1'b1, 8'h77, 3'd1, 3'b111, 1'b1, 1'b0, 3'd1);
      idle(1'b0, 3'd0);
      // Single push, observed the next cycle, then drained.
      push1(8'h3C, 3'd5, 1'b0);
      idle(1'b0, 3'd5);
      idle(1'b1, 3'd5);
      // Fill, drop a push while full, drain in order.
      push1(8'h01, 3'd1, 1'b0);
      push1(8'h02, 3'd2, 1'b0);
      push1(8'h03, 3'd3, 1'b0);
      idle(1'b1, 3'd3);
      idle(1'b1, 3'd2);
      idle(1'b0, 3'd0);
      // Simultaneous push and pop at Count=1, across pointer wrap.
      push1(8'h55, 3'd6, 1'b0);
      push1(8'hAA, 3'd7, 1'b1);
      idle(1'b0, 3'd7);
      push1(8'hBB, 3'd4, 1'b1);
      idle(1'b1, 3'd4);
      idle(1'b0, 3'd0);
      // Flag write and flag hold.
      step(1'b1, 1'b1, 8'h00, 3'd2, 3'b100, 1'b1, 1'b1, 3'd0);
      step(1'b1, 1'b1, 8'h81, 3'd2, 3'b001, 1'b0, 1'b1, 3'd0);
      idle(1'b1, 3'd0);
      idle(1'b0, 3'd0);
      // Forwarding: youngest match, miss, then flush while full.
      push1(8'h10, 3'd3, 1'b0);
      push1(8'h20, 3'd3, 1'b0);
      idle(1'b0, 3'd3);
      idle(1'b0, 3'd4);
      step(1'b0, 1'b1, 8'h99, 3'd3, 3'b000, 1'b0, 1'b1, 3'd3);
      idle(1'b0, 3'd3);
      // Random traffic with occasional resets.
      repeat (800) begin
         step($urandom_range(0, 39) != 0, $urandom_range(0, 3) != 0, 8'($urandom), 3'($urandom),
              3'($urandom), $urandom_range(0, 1) != 0, $urandom_range(0, 2) != 0, 3'($urandom));
      end
      idle(1'b1, 3'd0);
      idle(1'b1, 3'd0);
      idle(1'b1, 3'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
